// File: rtl/int_div_sequencer.sv
// Vector radix-2 restoring divide/remainder sequencer; all lanes share one FSM and one iteration counter.
// Optional macro INT_DIV_EARLY_OUT_EN lets LOAD skip straight to FIXUP when every active lane has a trivial result.
module int_div_sequencer #(
  parameter int VEC_WIDTH = 4,
  parameter int DATA_W    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [1:0]                    op,
  input  logic [VEC_WIDTH-1:0]          lane_mask,
  input  logic [VEC_WIDTH*DATA_W-1:0]   a,
  input  logic [VEC_WIDTH*DATA_W-1:0]   b,
  output logic [VEC_WIDTH*DATA_W-1:0]   out,
  output logic                          out_valid,
  input  logic                          stall,
  output logic                          busy
);

  // state  | meaning
  // IDLE   | waiting for in_valid
  // LOAD   | operands captured; seed quotient with |a|
  // ITER   | one restoring step per cycle, DATA_W steps
  // FIXUP  | sign/exception/mask fix-up into out
  // DONE   | result held until stall drops
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ITER  = 3'd2;
  localparam logic [2:0] S_FIXUP = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic [VEC_WIDTH-1:0] mask_q, q_neg, r_neg, sgn_a, sgn_b;

  logic [VEC_WIDTH-1:0][DATA_W-1:0] a_v, b_v;
  logic [VEC_WIDTH-1:0][DATA_W-1:0] cap_a_mag, cap_b_mag;
  logic [VEC_WIDTH-1:0][DATA_W-1:0] a_raw, b_raw, a_mag, b_mag;
  logic [VEC_WIDTH-1:0][DATA_W-1:0] quo, rem, quo_nx, rem_nx;
  logic [VEC_WIDTH-1:0][DATA_W-1:0] q_fix, r_fix, res;
  logic [VEC_WIDTH-1:0][DATA_W:0]   rs, diff;

  assign a_v       = a;
  assign b_v       = b;
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  always_comb begin
    sgn_a = '0;
    sgn_b = '0;
    for (int i = 0; i < VEC_WIDTH; i++) begin
      sgn_a[i] = ~op[0] & a_v[i][DATA_W-1];
      sgn_b[i] = ~op[0] & b_v[i][DATA_W-1];
    end
  end

  // Negating MIN wraps to MIN, which reads correctly as the unsigned magnitude 2^(DATA_W-1).
  always_comb begin
    cap_a_mag = '0;
    cap_b_mag = '0;
    for (int i = 0; i < VEC_WIDTH; i++) begin
      cap_a_mag[i] = sgn_a[i] ? -a_v[i] : a_v[i];
      cap_b_mag[i] = sgn_b[i] ? -b_v[i] : b_v[i];
    end
  end

  // The shifted remainder needs one extra bit because unsigned divisors may use the full width.
  always_comb begin
    rs     = '0;
    diff   = '0;
    quo_nx = '0;
    rem_nx = '0;
    for (int i = 0; i < VEC_WIDTH; i++) begin
      rs[i]   = {rem[i], quo[i][DATA_W-1]};
      diff[i] = rs[i] - {1'b0, b_mag[i]};
      if (rs[i] >= {1'b0, b_mag[i]}) begin
        rem_nx[i] = diff[i][DATA_W-1:0];
        quo_nx[i] = {quo[i][DATA_W-2:0], 1'b1};
      end else begin
        rem_nx[i] = rs[i][DATA_W-1:0];
        quo_nx[i] = {quo[i][DATA_W-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    q_fix = '0;
    r_fix = '0;
    res   = '0;
    for (int i = 0; i < VEC_WIDTH; i++) begin
      q_fix[i] = q_neg[i] ? -quo[i] : quo[i];
      r_fix[i] = r_neg[i] ? -rem[i] : rem[i];
      if (!mask_q[i])
        res[i] = '0;
      else if (b_raw[i] == '0)
        res[i] = op_q[1] ? a_raw[i] : '1;
      else if (!op_q[0] && a_raw[i] == MIN_V && b_raw[i] == '1)
        res[i] = op_q[1] ? '0 : MIN_V;
      else
        res[i] = op_q[1] ? r_fix[i] : q_fix[i];
    end
  end

`ifdef INT_DIV_EARLY_OUT_EN
  logic early_ok;

  always_comb begin
    early_ok = 1'b1;
    for (int i = 0; i < VEC_WIDTH; i++)
      if (mask_q[i] && b_raw[i] != '0 && !(a_mag[i] < b_mag[i]))
        early_ok = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      out   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q   <= op;
            mask_q <= lane_mask;
            a_raw  <= a_v;
            b_raw  <= b_v;
            a_mag  <= cap_a_mag;
            b_mag  <= cap_b_mag;
            q_neg  <= sgn_a ^ sgn_b;
            r_neg  <= sgn_a;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt   <= '0;
          rem   <= '0;
          quo   <= a_mag;
          state <= S_ITER;
`ifdef INT_DIV_EARLY_OUT_EN
          if (early_ok) begin
            quo   <= '0;
            rem   <= a_mag;
            state <= S_FIXUP;
          end
`endif
        end
        S_ITER: begin
          quo <= quo_nx;
          rem <= rem_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W-1))
            state <= S_FIXUP;
        end
        S_FIXUP: begin
          out   <= res;
          state <= S_DONE;
        end
        S_DONE: begin
          if (!stall)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_div_sequencer.sv
// Directed bench for int_div_sequencer: timeline/arithmetic reference model plus literal expectations.
// Honours INT_DIV_EARLY_OUT_EN when it is defined for the build.
module tb_int_div_sequencer;
  localparam int VW  = 4;
  localparam int DW  = 32;
  localparam int LAT = DW + 2;
  localparam logic [DW-1:0] MINV = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [1:0] op = 2'b00;
  logic [VW-1:0] lane_mask = '0;
  logic [VW*DW-1:0] a = '0;
  logic [VW*DW-1:0] b = '0;
  logic [VW*DW-1:0] out;
  logic out_valid;
  logic stall = 1'b0;
  logic busy;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  int phase = 0;
  int m_cnt = 0;
  int m_lat = LAT;
  logic [VW*DW-1:0] m_pend = '0;
  logic [VW*DW-1:0] m_out = '0;

  int_div_sequencer #(.VEC_WIDTH(VW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op(op), .lane_mask(lane_mask),
    .a(a), .b(b), .out(out), .out_valid(out_valid), .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [VW*DW-1:0] pack(input logic [DW-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [DW-1:0] lane_ref(input logic [1:0] o, input logic [DW-1:0] x, y);
    logic signed [DW-1:0] sx, sy;
    sx = x;
    sy = y;
    if (y == '0) return o[1] ? x : '1;
    if (!o[0]) begin
      if (x == MINV && y == '1) return o[1] ? '0 : MINV;
      return o[1] ? sx % sy : sx / sy;
    end
    return o[1] ? x % y : x / y;
  endfunction

  function automatic logic [VW*DW-1:0] vec_ref(input logic [1:0] o, input logic [VW-1:0] m,
                                               input logic [VW*DW-1:0] av, bv);
    logic [VW*DW-1:0] r;
    r = '0;
    for (int i = 0; i < VW; i++)
      if (m[i]) r[i*DW +: DW] = lane_ref(o, av[i*DW +: DW], bv[i*DW +: DW]);
    return r;
  endfunction

`ifdef INT_DIV_EARLY_OUT_EN
  function automatic logic [DW-1:0] mag(input logic sgn, input logic [DW-1:0] x);
    return (sgn && x[DW-1]) ? -x : x;
  endfunction

  function automatic bit early_ref(input logic [1:0] o, input logic [VW-1:0] m,
                                   input logic [VW*DW-1:0] av, bv);
    for (int i = 0; i < VW; i++)
      if (m[i] && bv[i*DW +: DW] != '0 &&
          !(mag(!o[0], av[i*DW +: DW]) < mag(!o[0], bv[i*DW +: DW])))
        return 1'b0;
    return 1'b1;
  endfunction
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = LAT;
`endif

  task automatic check(input string name, input logic [VW*DW-1:0] act, input logic [VW*DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference timeline: idle (0), in flight (1), result held (2).
  always @(posedge clk) begin
    if (rst) begin
      phase = 0;
      m_out = '0;
    end else begin
      case (phase)
        0: if (in_valid) begin
          phase  = 1;
          m_cnt  = 0;
          m_pend = vec_ref(op, lane_mask, a, b);
`ifdef INT_DIV_EARLY_OUT_EN
          m_lat  = early_ref(op, lane_mask, a, b) ? 2 : LAT;
`else
          m_lat  = LAT;
`endif
        end
        1: begin
          m_cnt++;
          if (m_cnt == m_lat) begin
            phase = 2;
            m_out = m_pend;
          end
        end
        default: if (!stall) phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {127'b0, busy}, {127'b0, phase != 0});
      check("out_valid", {127'b0, out_valid}, {127'b0, phase == 2});
      if (phase == 2) check("out", out, m_out);
    end
  end

  task automatic wait_valid(output int k);
    k = 0;
    while (k < 100) begin
      @(posedge clk);
      k++;
      #1;
      if (out_valid) break;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [VW-1:0] m,
                        input logic [VW*DW-1:0] av, bv, exp, input int exp_lat);
    int k;
    @(negedge clk);
    op = o; lane_mask = m; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(k);
    check({name, "_latency"}, k, exp_lat);
    check({name, "_out"}, out, exp);
    check({name, "_model"}, m_out, exp);
    @(posedge clk);
    #1 check({name, "_valid_1cyc"}, {127'b0, out_valid}, '0);
  endtask

  initial begin
    logic [VW*DW-1:0] exp_v;
    int k;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", {127'b0, busy}, '0);
    check("reset_valid", {127'b0, out_valid}, '0);
    check("reset_out", out, '0);

    run_op("div_signs", 2'b00, 4'b1111, pack(100, -32'sd100, 7, -32'sd7),
           pack(7, 7, -32'sd2, -32'sd2), pack(14, -32'sd14, -32'sd3, 3), LAT);
    run_op("rem_neg", 2'b10, 4'b1111, {4{32'hFFFF_FFF9}}, {4{32'd2}}, {4{32'hFFFF_FFFF}}, LAT);
    run_op("remu", 2'b11, 4'b1111, {4{32'hFFFF_FFF9}}, {4{32'd2}}, {4{32'd1}}, LAT);
    run_op("div_exc", 2'b00, 4'b1111, pack(5, MINV, 0, 9), pack(0, 32'hFFFF_FFFF, 3, 0),
           pack(32'hFFFF_FFFF, MINV, 0, 32'hFFFF_FFFF), LAT);
    run_op("rem_exc", 2'b10, 4'b1111, pack(5, MINV, 0, 9), pack(0, 32'hFFFF_FFFF, 3, 0),
           pack(5, 0, 0, 9), LAT);
    run_op("divu_wide", 2'b01, 4'b1111, pack(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1000, 0),
           pack(32'h8000_0001, 1, 7, 5), pack(1, 32'hFFFF_FFFF, 142, 0), LAT);
    run_op("mask_zero", 2'b00, 4'b0000, pack(100, 200, 300, 400), {4{32'd3}}, '0, EARLY_LAT);

    // Masked DIVU held under stall, with the next request waiting on busy.
    stall = 1'b1;
    exp_v = pack(5, 0, 5, 0);
    @(negedge clk);
    op = 2'b01; lane_mask = 4'b0101; a = {4{32'd20}}; b = {4{32'd4}}; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_valid(k);
    check("stall_latency", k, LAT);
    op = 2'b01; lane_mask = 4'b1111; a = {4{32'd9}}; b = {4{32'd3}}; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_hold_valid", {127'b0, out_valid}, {127'b0, 1'b1});
      check("stall_hold_out", out, exp_v);
      @(posedge clk);
      #1;
    end
    check("stall_last_out", out, exp_v);
    stall = 1'b0;
    @(posedge clk);
    #1 check("release_busy", {127'b0, busy}, '0);
    check("release_valid", {127'b0, out_valid}, '0);
    @(posedge clk);
    #1 check("held_req_accept", {127'b0, busy}, {127'b0, 1'b1});
    in_valid = 1'b0;
    wait_valid(k);
    check("held_req_latency", k, LAT);
    check("held_req_out", out, {4{32'd3}});

    // Reset in the 10th ITER cycle.
    @(posedge clk);
    @(negedge clk);
    op = 2'b01; lane_mask = 4'b1111; a = {4{32'd1000}}; b = {4{32'd3}}; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_busy", {127'b0, busy}, '0);
    check("midrst_valid", {127'b0, out_valid}, '0);
    check("midrst_out", out, '0);
    run_op("after_rst", 2'b01, 4'b1111, {4{32'd9}}, {4{32'd3}}, {4{32'd3}}, LAT);

    run_op("small_divu", 2'b01, 4'b1111, {4{32'd3}}, {4{32'd10}}, '0, EARLY_LAT);
    run_op("one_big_lane", 2'b01, 4'b1111, pack(30, 3, 3, 3), {4{32'd10}}, pack(3, 0, 0, 0), LAT);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
